// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory req/ack read bus
interface fetch_sequencer_if #(
  parameter int IR_W = 16
);
  logic            o_mem_req;
  logic [7:0]      o_mem_addr;
  logic            i_mem_ack;
  logic [IR_W-1:0] i_mem_data;

  modport master (
    output o_mem_req,
    output o_mem_addr,
    input  i_mem_ack,
    input  i_mem_data
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_addr,
    output i_mem_ack,
    output i_mem_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode sequencer driving the jump unit PC commands
module fetch_sequencer #(
  parameter int IR_W    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [7:0]          i_pc,
  fetch_sequencer_if.master   mem,
  input  logic [2:0]          i_flags,
  input  logic                i_flags_we,
  output logic                o_alu_en,
  output logic [IR_W-1:0]     o_ir,
  output logic [3:0]          o_condJ,
  output logic [7:0]          o_rx,
  output logic [2:0]          o_ban,
  output logic                o_halt,
  output logic                o_fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] OP_HALT  = 4'b0111;

  state_t          state, state_nxt;
  logic [IR_W-1:0] ir;
  logic [2:0]      ban;
  logic [7:0]      cnt;
  logic [3:0]      opcode;
  logic            mem_req;

  assign opcode = ir[IR_W-1 -: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (i_en) state_nxt = S_WAIT;
      S_WAIT: begin
        // ack wins over timeout when both land on the same cycle
        if (mem.i_mem_ack)        state_nxt = S_DECODE;
        else if (cnt == CNT_LAST) state_nxt = S_FAULT;
      end
      S_DECODE: state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    o_alu_en = 1'b0;
    o_condJ  = 4'b0000;
    o_halt   = 1'b0;
    o_fault  = 1'b0;
    case (state)
      S_WAIT: mem_req = 1'b1;
      S_EXEC: begin
        if (opcode[3]) begin
          o_condJ = opcode;
        end else begin
          o_condJ  = 4'b0001;
          o_alu_en = (opcode != 4'b0000);
        end
      end
      S_HALT:  o_halt  = 1'b1;
      S_FAULT: o_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir  <= '0;
      cnt <= '0;
    end else begin
      if (state == S_FETCH && i_en) cnt <= '0;
      else if (state == S_WAIT)     cnt <= cnt + 8'd1;
      if (state == S_WAIT && mem.i_mem_ack) ir <= mem.i_mem_data;
    end
  end

  // a jump in EXEC sees the flags latched before its edge; a same-edge write lands afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ban <= 3'b000;
    end else if (i_flags_we && state != S_HALT && state != S_FAULT) begin
      ban <= {i_flags[2], i_flags[1], i_flags[0]};
    end
  end

  assign mem.o_mem_req  = mem_req;
  assign mem.o_mem_addr = mem_req ? i_pc : 8'h00;
  assign o_ir           = ir;
  assign o_rx           = ir[7:0];
  assign o_ban          = ban;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [7:0]  i_pc;
  logic [2:0]  i_flags;
  logic        i_flags_we;
  logic        o_alu_en;
  logic [15:0] o_ir;
  logic [3:0]  o_condJ;
  logic [7:0]  o_rx;
  logic [2:0]  o_ban;
  logic        o_halt;
  logic        o_fault;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer_if #(.IR_W(16)) mem_if ();

  fetch_sequencer #(.IR_W(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_pc       (i_pc),
    .mem        (mem_if.master),
    .i_flags    (i_flags),
    .i_flags_we (i_flags_we),
    .o_alu_en   (o_alu_en),
    .o_ir       (o_ir),
    .o_condJ    (o_condJ),
    .o_rx       (o_rx),
    .o_ban      (o_ban),
    .o_halt     (o_halt),
    .o_fault    (o_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_pc = 8'h00; i_flags = 3'b000; i_flags_we = 1'b0;
    mem_if.i_mem_ack = 1'b0; mem_if.i_mem_data = 16'h0000;
    cyc(); cyc();
    check("rst_req",   32'(mem_if.o_mem_req), 32'h0);
    check("rst_addr",  32'(mem_if.o_mem_addr), 32'h00);
    check("rst_condj", 32'(o_condJ), 32'h0);
    check("rst_ir",    32'(o_ir), 32'h0);
    check("rst_ban",   32'(o_ban), 32'h0);
    check("rst_alu",   32'(o_alu_en), 32'h0);
    check("rst_halt",  32'(o_halt), 32'h0);
    check("rst_fault", 32'(o_fault), 32'h0);
    rst = 1'b0;

    // NOP with ack after two WAIT cycles
    i_pc = 8'h00; i_en = 1'b1;
    check("nop_fetch_condj", 32'(o_condJ), 32'h0);
    cyc(); i_en = 1'b0;
    check("nop_w1_req",  32'(mem_if.o_mem_req), 32'h1);
    check("nop_w1_addr", 32'(mem_if.o_mem_addr), 32'h00);
    cyc(); mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'h0000;
    check("nop_w2_req", 32'(mem_if.o_mem_req), 32'h1);
    cyc(); mem_if.i_mem_ack = 1'b0;
    check("nop_dec_req",   32'(mem_if.o_mem_req), 32'h0);
    check("nop_dec_condj", 32'(o_condJ), 32'h0);
    cyc();
    check("nop_exec_condj", 32'(o_condJ), 32'h1);
    check("nop_exec_alu",   32'(o_alu_en), 32'h0);
    cyc();
    check("nop_after_condj", 32'(o_condJ), 32'h0);
    check("nop_after_req",   32'(mem_if.o_mem_req), 32'h0);

    // ALU op with ack in the first WAIT cycle
    i_pc = 8'h10; i_en = 1'b1;
    cyc(); i_en = 1'b0; mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'h1234;
    check("alu_addr", 32'(mem_if.o_mem_addr), 32'h10);
    cyc(); mem_if.i_mem_ack = 1'b0;
    check("alu_ir",        32'(o_ir), 32'h1234);
    check("alu_dec_condj", 32'(o_condJ), 32'h0);
    check("alu_dec_alu",   32'(o_alu_en), 32'h0);
    cyc();
    check("alu_exec_alu",   32'(o_alu_en), 32'h1);
    check("alu_exec_condj", 32'(o_condJ), 32'h1);
    cyc();
    check("alu_after_alu", 32'(o_alu_en), 32'h0);
    check("alu_after_addr", 32'(mem_if.o_mem_addr), 32'h00);

    // conditional jump using latched flags
    i_pc = 8'h11; i_flags = 3'b001; i_flags_we = 1'b1; i_en = 1'b1;
    cyc(); i_flags_we = 1'b0; i_flags = 3'b000; i_en = 1'b0;
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'hA042;
    check("jmp_ban_latched", 32'(o_ban), 32'h1);
    cyc(); mem_if.i_mem_ack = 1'b0;
    cyc();
    check("jmp_exec_condj", 32'(o_condJ), 32'hA);
    check("jmp_exec_rx",    32'(o_rx), 32'h42);
    check("jmp_exec_ban",   32'(o_ban), 32'h1);
    cyc();

    // flag write during EXEC lands only after EXEC
    i_pc = 8'h42; i_en = 1'b1;
    cyc(); i_en = 1'b0; mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'hA042;
    cyc(); mem_if.i_mem_ack = 1'b0;
    cyc(); i_flags = 3'b000; i_flags_we = 1'b1;
    check("jmp2_exec_ban",   32'(o_ban), 32'h1);
    check("jmp2_exec_condj", 32'(o_condJ), 32'hA);
    cyc(); i_flags_we = 1'b0;
    check("jmp2_after_ban", 32'(o_ban), 32'h0);

    // HALT
    i_pc = 8'h20; i_en = 1'b1;
    cyc(); i_en = 1'b0; mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'h7000;
    cyc(); mem_if.i_mem_ack = 1'b0;
    check("halt_dec", 32'(o_halt), 32'h0);
    cyc();
    check("halt_set", 32'(o_halt), 32'h1);
    i_en = 1'b1; i_flags = 3'b111; i_flags_we = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("halt_req",   32'(mem_if.o_mem_req), 32'h0);
      check("halt_condj", 32'(o_condJ), 32'h0);
      cyc();
    end
    check("halt_hold", 32'(o_halt), 32'h1);
    check("halt_ban",  32'(o_ban), 32'h0);
    i_flags_we = 1'b0; i_en = 1'b0;
    #1 rst = 1'b1;
    #1 check("halt_rst", 32'(o_halt), 32'h0);
    cyc(); rst = 1'b0;

    // memory timeout
    i_en = 1'b1;
    cyc(); i_en = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check("to_wait_req",   32'(mem_if.o_mem_req), 32'h1);
      check("to_wait_fault", 32'(o_fault), 32'h0);
      cyc();
    end
    check("to_fault",     32'(o_fault), 32'h1);
    check("to_fault_req", 32'(mem_if.o_mem_req), 32'h0);
    cyc();
    check("to_fault_hold", 32'(o_fault), 32'h1);
    #1 rst = 1'b1;
    #1 check("to_rst", 32'(o_fault), 32'h0);
    cyc(); rst = 1'b0;

    // ack on the last permitted WAIT cycle
    i_en = 1'b1;
    cyc(); i_en = 1'b0;
    repeat (14) cyc();
    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'h0000;
    check("ack15_req", 32'(mem_if.o_mem_req), 32'h1);
    cyc(); mem_if.i_mem_ack = 1'b0;
    check("ack15_fault", 32'(o_fault), 32'h0);
    check("ack15_req_dec", 32'(mem_if.o_mem_req), 32'h0);
    cyc();
    check("ack15_exec_condj", 32'(o_condJ), 32'h1);
    cyc();

    // reset in the middle of WAIT
    i_pc = 8'h33; i_en = 1'b1; i_flags = 3'b110; i_flags_we = 1'b1;
    cyc(); i_en = 1'b0; i_flags_we = 1'b0;
    check("rw_req", 32'(mem_if.o_mem_req), 32'h1);
    check("rw_ban", 32'(o_ban), 32'h6);
    #1 rst = 1'b1;
    #1;
    check("rw_rst_req",  32'(mem_if.o_mem_req), 32'h0);
    check("rw_rst_addr", 32'(mem_if.o_mem_addr), 32'h00);
    check("rw_rst_ban",  32'(o_ban), 32'h0);
    cyc(); rst = 1'b0;

    // restart, then reset in the middle of EXEC
    i_en = 1'b1;
    cyc(); i_en = 1'b0; mem_if.i_mem_ack = 1'b1; mem_if.i_mem_data = 16'h9012;
    check("re_req", 32'(mem_if.o_mem_req), 32'h1);
    cyc(); mem_if.i_mem_ack = 1'b0;
    cyc();
    check("re_exec_condj", 32'(o_condJ), 32'h9);
    check("re_exec_ir",    32'(o_ir), 32'h9012);
    #1 rst = 1'b1;
    #1;
    check("re_rst_condj", 32'(o_condJ), 32'h0);
    check("re_rst_ir",    32'(o_ir), 32'h0);
    check("re_rst_alu",   32'(o_alu_en), 32'h0);
    cyc(); rst = 1'b0;
    check("re_idle_req", 32'(mem_if.o_mem_req), 32'h0);
    i_en = 1'b1;
    cyc(); i_en = 1'b0;
    check("re_restart_req", 32'(mem_if.o_mem_req), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch/decode sequencer for the 8-bit core. It sits directly upstream of the jump/PC unit and drives its condJ, Rx and Ban inputs.
- It reads the PC value, fetches a 16-bit instruction over a req/ack memory handshake, and holds it in the instruction register.
- It keeps the flag register and issues exactly one PC-advance or jump command per instruction.
- It also detects HALT and memory-timeout faults.

Parameters:
- IR_W, 16, instruction width; opcode is ir[IR_W-1:IR_W-4], immediate/target is ir[7:0].
- TIMEOUT, 15, maximum cycles to wait for i_mem_ack before a fault (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_en  in  1  run enable; sampled only in FETCH
- i_pc  in  8  current PC from the jump unit (memory address source)
- o_mem_req  out  1  instruction read request, level, held until ack
- o_mem_addr  out  8  equals i_pc while o_mem_req=1, else 0
- i_mem_ack  in  1  read data valid
- i_mem_data  in  IR_W  instruction word
- i_flags  in  3  ALU flags {neg, carry, zero}
- i_flags_we  in  1  flag register write strobe
- o_alu_en  out  1  one-cycle ALU execute strobe
- o_ir  out  IR_W  instruction register
- o_condJ  out  4  PC command to the jump unit
- o_rx  out  8  jump target, equals o_ir[7:0]
- o_ban  out  3  latched flags: [0]=zero, [1]=carry, [2]=negative
- o_halt  out  1  halted
- o_fault  out  1  memory timeout fault

Behaviour:
- Reset (async) values:
  - State is FETCH.
  - o_ir=0, o_ban=000, o_condJ=0000, o_alu_en=0, o_mem_req=0, o_halt=0, o_fault=0, timeout counter=0.
- States: FETCH, WAIT, DECODE, EXEC, HALT, FAULT. All state, ir, ban and counter are registered. o_condJ, o_alu_en, o_mem_req and o_mem_addr are decoded combinationally from the state and ir, with no added latency.
- FETCH:
  - If i_en=1: go to WAIT and clear the counter. Otherwise stay.
  - o_condJ=0000.
- WAIT:
  - o_mem_req=1; the counter increments each cycle.
  - If i_mem_ack=1: ir<=i_mem_data, go to DECODE. Ack in the first WAIT cycle is legal, giving 1-cycle latency.
  - Else if counter==TIMEOUT-1: go to FAULT.
  - Ack has priority over timeout in the same cycle.
  - i_mem_ack outside WAIT is ignored.
- DECODE:
  - One cycle; o_condJ=0000.
  - If opcode==0111: go to HALT. Otherwise go to EXEC.
- EXEC (one cycle), by opcode:
  - 1000..1111: o_condJ=opcode (jump/conditional jump); o_alu_en=0.
  - 0001..0110: o_condJ=0001; o_alu_en=1.
  - 0000 (NOP): o_condJ=0001; o_alu_en=0.
  - Next state is FETCH. The PC changes at the edge ending EXEC, so the next FETCH/WAIT uses the new i_pc.
- Exactly one nonzero o_condJ cycle per instruction. In all other states o_condJ=0000 (PC hold).
- Flags:
  - o_ban<={i_flags[2],i_flags[1],i_flags[0]} on any edge where i_flags_we=1, in any state except HALT/FAULT.
  - A conditional jump in EXEC uses the o_ban value registered before that edge. A simultaneous i_flags_we only affects later instructions.
- HALT: o_halt=1, o_condJ=0000, no memory requests. It is left only by rst.
- FAULT: o_fault=1, o_condJ=0000, o_mem_req=0. It is left only by rst.
- Reset mid-operation: any state returns to FETCH immediately, o_mem_req drops asynchronously, and the ir/flags are cleared.
- i_en=0 while not in FETCH has no effect; the current instruction completes.

Test Plan:
- Reset, i_en=1, i_pc=0x00, memory acks after 2 WAIT cycles with 0x0000 (NOP) -> exactly one EXEC cycle with o_condJ=0001; o_mem_req high for 2 cycles then low.
- Fetch 0x1234 (ALU op 1) with ack in the first WAIT cycle -> o_ir=0x1234, o_alu_en=1 and o_condJ=0001 in the same single EXEC cycle.
- Drive i_flags=001 with i_flags_we=1, then fetch 0xA042 -> EXEC o_condJ=1010, o_rx=0x42, o_ban=001. Repeat with i_flags_we asserted during EXEC carrying 000 -> o_ban changes only after EXEC.
- Fetch 0x7000 -> o_halt=1 two cycles after ack. No further o_mem_req for 20 cycles; o_condJ stays 0000.
- Never ack with TIMEOUT=15 -> o_fault=1 after 15 WAIT cycles. Ack on cycle 15 exactly -> no fault, DECODE entered.
- Assert rst in the middle of WAIT and of EXEC -> all outputs return to reset values in the same cycle; the sequence restarts at FETCH after release.
